// File: rtl/hasti_rr_mem_arbiter_if.sv
// HASTI (AHB-lite) bundle of N ports packed side by side; port i sits at slice i.
// Signals: haddr/hwrite/hsize/htrans/hwdata from master, hrdata/hready/hresp from slave.
interface hasti_rr_mem_arbiter_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N*ADDR_W-1:0] haddr;
    logic [N-1:0]        hwrite;
    logic [N*3-1:0]      hsize;
    logic [N*2-1:0]      htrans;
    logic [N*DATA_W-1:0] hwdata;
    logic [N*DATA_W-1:0] hrdata;
    logic [N-1:0]        hready;
    logic [N-1:0]        hresp;

    modport master (
        output haddr, hwrite, hsize, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/hasti_rr_mem_arbiter.sv
// N-port HASTI data-memory arbiter: merges core dmem ports onto one shared SRAM.
// Ports: clk, reset (sync, active-high), m (core-facing bundle, NUM_PORTS wide),
//        s (SRAM-facing bundle, 1 wide), next_core (MODE 0 select), grant_valid/grant_idx.
module hasti_rr_mem_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MODE      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    hasti_rr_mem_arbiter_if.slave  m,
    hasti_rr_mem_arbiter_if.master s,
    input  logic [IDX_W-1:0]       next_core,
    output logic                   grant_valid,
    output logic [IDX_W-1:0]       grant_idx
);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] own;
    logic                 gnt_v;
    logic [IDX_W-1:0]     gnt_i;
    logic [IDX_W-1:0]     rr_ptr;
    logic                 dp_valid;
    logic [IDX_W-1:0]     dp_idx;
    logic [NUM_PORTS-1:0] buf_valid;
    logic [DATA_W-1:0]    buf_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] buf_resp;

    logic [NUM_PORTS-1:0]        hready_o;
    logic [NUM_PORTS*DATA_W-1:0] hrdata_o;
    logic [NUM_PORTS-1:0]        hresp_o;

    // NONSEQ/SEQ both have htrans[1] set; IDLE/BUSY do not
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i] = m.htrans[2*i+1];
        end
    end

    // Round-robin scan runs from farthest to nearest so the nearest
    // requester after rr_ptr is the last (winning) assignment.
    always_comb begin
        int scan;
        scan  = 0;
        gnt_v = 1'b0;
        gnt_i = '0;
        if (MODE == 0) begin
            if (int'(next_core) < NUM_PORTS && req[next_core]) begin
                gnt_v = 1'b1;
                gnt_i = next_core;
            end
        end else begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                scan = (int'(rr_ptr) + k) % NUM_PORTS;
                if (req[scan]) begin
                    gnt_v = 1'b1;
                    gnt_i = IDX_W'(scan);
                end
            end
        end
        if (reset) begin
            gnt_v = 1'b0;
            gnt_i = '0;
        end
    end

    assign grant_valid = gnt_v;
    assign grant_idx   = gnt_i;

    always_comb begin
        own = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            own[i] = gnt_v && (gnt_i == IDX_W'(i));
        end
    end

    // Address phase to the slave
    always_comb begin
        s.haddr  = '0;
        s.hwrite = 1'b0;
        s.hsize  = 3'b000;
        s.htrans = HTRANS_IDLE;
        if (gnt_v) begin
            s.haddr  = m.haddr[int'(gnt_i)*ADDR_W +: ADDR_W];
            s.hwrite = m.hwrite[gnt_i];
            s.hsize  = m.hsize[int'(gnt_i)*3 +: 3];
            s.htrans = m.htrans[int'(gnt_i)*2 +: 2];
        end
    end

    // Write data follows the data-phase owner, one cycle behind its address
    always_comb begin
        s.hwdata = '0;
        if (dp_valid && !reset) begin
            s.hwdata = m.hwdata[int'(dp_idx)*DATA_W +: DATA_W];
        end
    end

    // Per-port response: buffered response first, then live data phase,
    // otherwise only the address-phase acceptance matters.
    always_comb begin
        hready_o = '0;
        hrdata_o = '0;
        hresp_o  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset) begin
                hready_o[i] = 1'b1;
            end else if (buf_valid[i]) begin
                hready_o[i] = !req[i] || (own[i] && s.hready);
                hrdata_o[i*DATA_W +: DATA_W] = buf_data[i];
                hresp_o[i] = buf_resp[i];
            end else if (dp_valid && dp_idx == IDX_W'(i)) begin
                hready_o[i] = s.hready && (!req[i] || own[i]);
                hrdata_o[i*DATA_W +: DATA_W] = s.hrdata;
                hresp_o[i] = s.hresp;
            end else begin
                hready_o[i] = !req[i] || (own[i] && s.hready);
            end
        end
    end

    assign m.hready = hready_o;
    assign m.hrdata = hrdata_o;
    assign m.hresp  = hresp_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_valid  <= 1'b0;
            dp_idx    <= '0;
            rr_ptr    <= IDX_W'(NUM_PORTS-1);
            buf_valid <= '0;
        end else begin
            if (s.hready) begin
                dp_valid <= gnt_v;
                dp_idx   <= gnt_i;
                if (gnt_v) begin
                    rr_ptr <= gnt_i;
                end
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (buf_valid[i] && hready_o[i]) begin
                    buf_valid[i] <= 1'b0;
                end
                // Data phase completes but the port's next request lost:
                // park the response until that request is accepted.
                if (s.hready && dp_valid && dp_idx == IDX_W'(i)
                    && req[i] && !own[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_data[i]  <= s.hrdata;
                    buf_resp[i]  <= s.hresp;
                end
            end
        end
    end
endmodule

// File: tb/tb_hasti_rr_mem_arbiter.sv
// Directed testbench for hasti_rr_mem_arbiter (round-robin and select modes).
// Drives inputs on the falling edge and checks outputs shortly after.
module tb_hasti_rr_mem_arbiter;
    localparam int NP = 4;
    localparam int IW = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NP*AW-1:0] m_haddr;
    logic [NP-1:0]    m_hwrite;
    logic [NP*3-1:0]  m_hsize;
    logic [NP*2-1:0]  m_htrans;
    logic [NP*DW-1:0] m_hwdata;
    logic [DW-1:0]    s_hrdata;
    logic             s_hready;
    logic             s_hresp;
    logic [IW-1:0]    next_core;

    logic          gv1, gv0;
    logic [IW-1:0] gi1, gi0;

    hasti_rr_mem_arbiter_if #(.N(NP), .ADDR_W(AW), .DATA_W(DW)) mi1 ();
    hasti_rr_mem_arbiter_if #(.N(1),  .ADDR_W(AW), .DATA_W(DW)) si1 ();
    hasti_rr_mem_arbiter_if #(.N(NP), .ADDR_W(AW), .DATA_W(DW)) mi0 ();
    hasti_rr_mem_arbiter_if #(.N(1),  .ADDR_W(AW), .DATA_W(DW)) si0 ();

    assign mi1.haddr  = m_haddr;
    assign mi1.hwrite = m_hwrite;
    assign mi1.hsize  = m_hsize;
    assign mi1.htrans = m_htrans;
    assign mi1.hwdata = m_hwdata;
    assign si1.hrdata = s_hrdata;
    assign si1.hready = s_hready;
    assign si1.hresp  = s_hresp;
    assign mi0.haddr  = m_haddr;
    assign mi0.hwrite = m_hwrite;
    assign mi0.hsize  = m_hsize;
    assign mi0.htrans = m_htrans;
    assign mi0.hwdata = m_hwdata;
    assign si0.hrdata = s_hrdata;
    assign si0.hready = s_hready;
    assign si0.hresp  = s_hresp;

    hasti_rr_mem_arbiter #(
        .NUM_PORTS(NP), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW), .MODE(1)
    ) dut (
        .clk(clk), .reset(reset), .m(mi1), .s(si1),
        .next_core(next_core), .grant_valid(gv1), .grant_idx(gi1)
    );

    hasti_rr_mem_arbiter #(
        .NUM_PORTS(NP), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW), .MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .m(mi0), .s(si0),
        .next_core(next_core), .grant_valid(gv0), .grant_idx(gi0)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] rd(int p);
        return mi1.hrdata[p*DW +: DW];
    endfunction

    task automatic idle_all();
        m_haddr  = '0;
        m_hwrite = '0;
        m_hsize  = '0;
        m_htrans = '0;
        m_hwdata = '0;
        s_hrdata = '0;
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        next_core = '0;
    endtask

    task automatic set_port(int p, logic [1:0] tr, logic wr, logic [AW-1:0] a);
        m_htrans[p*2 +: 2]  = tr;
        m_hwrite[p]         = wr;
        m_haddr[p*AW +: AW] = a;
        m_hsize[p*3 +: 3]   = 3'b010;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        idle_all();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        reset = 1'b1;
        idle_all();
        set_port(0, 2'b10, 1'b0, 32'h100);
        set_port(2, 2'b11, 1'b0, 32'h200);
        #1;
        n_cmp++;
        if (si1.htrans !== 2'b00) begin
            n_err++;
            $display("FAIL reset_htrans: got %b want 00", si1.htrans);
        end
        n_cmp++;
        if (gv1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_grant_valid: got %b want 0", gv1);
        end
        n_cmp++;
        if (mi1.hready !== 4'hF) begin
            n_err++;
            $display("FAIL reset_hready: got %h want f", mi1.hready);
        end
        n_cmp++;
        if (mi1.hrdata !== '0 || mi1.hresp !== 4'h0) begin
            n_err++;
            $display("FAIL reset_hrdata: got %h/%h want 0/0", mi1.hrdata, mi1.hresp);
        end
        next_cycle();
        reset = 1'b0;
        idle_all();
    endtask

    task automatic test_single_read();
        do_reset();
        set_port(0, 2'b10, 1'b0, 32'h10);
        #1;
        n_cmp++;
        if (si1.haddr !== 32'h10 || si1.htrans !== 2'b10) begin
            n_err++;
            $display("FAIL single_addr: got %h/%b want 10/10", si1.haddr, si1.htrans);
        end
        n_cmp++;
        if (mi1.hready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL single_accept: got %b want 1", mi1.hready[0]);
        end
        next_cycle();
        set_port(0, 2'b00, 1'b0, 32'h0);
        s_hrdata = 32'hA5A5;
        #1;
        n_cmp++;
        if (rd(0) !== 32'hA5A5 || mi1.hready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL single_data: got %h/%b want a5a5/1", rd(0), mi1.hready[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [IW-1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int p = 0; p < NP; p++) begin
            set_port(p, 2'b10, 1'b0, 32'h1000 + 32'(p*4));
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (gv1 !== 1'b1 || gi1 !== exp_seq[c]) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: got %b/%0d want 1/%0d", c, gv1, gi1, exp_seq[c]);
            end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic deferred_prefix();
        set_port(0, 2'b10, 1'b0, 32'h4);
        #1;
        n_cmp++;
        if (gi1 !== 2'd0 || gv1 !== 1'b1) begin
            n_err++;
            $display("FAIL defer_c0_grant: got %b/%0d want 1/0", gv1, gi1);
        end
        next_cycle();
        set_port(0, 2'b10, 1'b0, 32'h8);
        set_port(1, 2'b10, 1'b0, 32'h40);
        s_hrdata = 32'hDEAD;
        #1;
        n_cmp++;
        if (gi1 !== 2'd1 || mi1.hready[0] !== 1'b0 || mi1.hready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL defer_c1: got grant=%0d hready=%b want 1, x10", gi1, mi1.hready[1:0]);
        end
    endtask

    task automatic test_deferred();
        do_reset();
        deferred_prefix();
        next_cycle();
        set_port(1, 2'b00, 1'b0, 32'h0);
        s_hrdata = 32'hBEEF;
        #1;
        n_cmp++;
        if (gi1 !== 2'd0 || si1.haddr !== 32'h8) begin
            n_err++;
            $display("FAIL defer_c2_grant: got %0d/%h want 0/8", gi1, si1.haddr);
        end
        n_cmp++;
        if (mi1.hready[0] !== 1'b1 || rd(0) !== 32'hDEAD) begin
            n_err++;
            $display("FAIL defer_c2_buf: got %b/%h want 1/dead", mi1.hready[0], rd(0));
        end
        n_cmp++;
        if (mi1.hready[1] !== 1'b1 || rd(1) !== 32'hBEEF) begin
            n_err++;
            $display("FAIL defer_c2_p1: got %b/%h want 1/beef", mi1.hready[1], rd(1));
        end
        next_cycle();
        idle_all();
    endtask

    task automatic test_mode0();
        do_reset();
        set_port(0, 2'b10, 1'b0, 32'h300);
        set_port(2, 2'b10, 1'b0, 32'h320);
        next_core = 2'd2;
        #1;
        n_cmp++;
        if (gv0 !== 1'b1 || gi0 !== 2'd2 || si0.haddr !== 32'h320) begin
            n_err++;
            $display("FAIL mode0_sel: got %b/%0d/%h want 1/2/320", gv0, gi0, si0.haddr);
        end
        next_cycle();
        next_core = 2'd3;
        #1;
        n_cmp++;
        if (gv0 !== 1'b0 || si0.htrans !== 2'b00) begin
            n_err++;
            $display("FAIL mode0_idle: got %b/%b want 0/00", gv0, si0.htrans);
        end
        next_cycle();
        idle_all();
    endtask

    task automatic test_wait_states();
        do_reset();
        set_port(1, 2'b10, 1'b1, 32'h20);
        #1;
        n_cmp++;
        if (gi1 !== 2'd1 || si1.hwrite !== 1'b1) begin
            n_err++;
            $display("FAIL wait_c0: got %0d/%b want 1/1", gi1, si1.hwrite);
        end
        next_cycle();
        set_port(1, 2'b00, 1'b0, 32'h0);
        set_port(0, 2'b10, 1'b0, 32'h50);
        set_port(2, 2'b10, 1'b0, 32'h60);
        m_hwdata[1*DW +: DW] = 32'h1234;
        s_hready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (mi1.hready[1] !== 1'b0 || si1.hwdata !== 32'h1234) begin
                n_err++;
                $display("FAIL wait_stall[%0d]: got %b/%h want 0/1234", c, mi1.hready[1], si1.hwdata);
            end
            next_cycle();
        end
        s_hready = 1'b1;
        #1;
        n_cmp++;
        if (mi1.hready[1] !== 1'b1 || si1.hwdata !== 32'h1234 || gi1 !== 2'd2) begin
            n_err++;
            $display("FAIL wait_release: got %b/%h/%0d want 1/1234/2", mi1.hready[1], si1.hwdata, gi1);
        end
        next_cycle();
        idle_all();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        deferred_prefix();
        next_cycle();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mi1.hready !== 4'hF || si1.htrans !== 2'b00 || gv1 !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_out: got %h/%b/%b want f/00/0", mi1.hready, si1.htrans, gv1);
        end
        next_cycle();
        reset = 1'b0;
        idle_all();
        for (int p = 0; p < NP; p++) begin
            set_port(p, 2'b10, 1'b0, 32'h2000 + 32'(p*4));
        end
        #1;
        n_cmp++;
        if (gv1 !== 1'b1 || gi1 !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_grant: got %b/%0d want 1/0", gv1, gi1);
        end
        n_cmp++;
        if (rd(0) !== 32'h0 || mi1.hready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_buf: got %h/%b want 0/1", rd(0), mi1.hready[0]);
        end
        next_cycle();
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_round_robin();
        test_deferred();
        test_mode0();
        test_wait_states();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
